// File: rtl/wb_defs.sv
// Shared definitions for the writeback queue: widths, default depth,
// the queued entry layout and the architectural zero register.
package wb_defs;

  localparam int XLEN             = 32;
  localparam int AW               = 5;
  localparam int DEFAULT_WB_DEPTH = 4;

  // One pending register-file write.
  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  // Writes to x0 have no architectural effect and are never queued.
  localparam logic [AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/wb_entry_store.sv
// Entry storage for the writeback queue: DEPTH entries, two write ports
// (lane 1 and lane 2 pushes) and two combinational read ports (head, head+1).
module wb_entry_store
  import wb_defs::*;
#(
  parameter int DEPTH = DEFAULT_WB_DEPTH
) (
  input  logic                     clk,
  input  logic                     we_a,
  input  logic [$clog2(DEPTH)-1:0] waddr_a,
  input  wb_entry_t                wdata_a,
  input  logic                     we_b,
  input  logic [$clog2(DEPTH)-1:0] waddr_b,
  input  wb_entry_t                wdata_b,
  input  logic [$clog2(DEPTH)-1:0] raddr_0,
  output wb_entry_t                rdata_0,
  input  logic [$clog2(DEPTH)-1:0] raddr_1,
  output wb_entry_t                rdata_1
);

  wb_entry_t mem [DEPTH];

  // Capture pushed entries; the two write addresses are always distinct.
  // NOTE: the array has no reset -- occupancy lives in the pointers/count,
  // so stale contents are never observed and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (we_a) mem[waddr_a] <= wdata_a;
    if (we_b) mem[waddr_b] <= wdata_b;
  end

  assign rdata_0 = mem[raddr_0];
  assign rdata_1 = mem[raddr_1];

endmodule

// File: rtl/writeback_queue.sv
// Dual-lane writeback buffer feeding the dual-port register file.
// Accepts up to two results per cycle, drains up to two per cycle in
// program order, and collapses same-cycle write-after-write pairs.
// Optional: define WB_TRACE_EN for a simulation-only write trace printed
// to the simulator log. XLEN/AW must match the wb_defs entry layout.
module writeback_queue
  import wb_defs::*;
#(
  parameter int DEPTH = DEFAULT_WB_DEPTH,
  parameter int XLEN  = wb_defs::XLEN,
  parameter int AW    = wb_defs::AW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_valid_1,
  input  logic [AW-1:0]            wb_rd_1,
  input  logic [XLEN-1:0]          wb_data_1,
  output logic                     wb_ready_1,
  input  logic                     wb_valid_2,
  input  logic [AW-1:0]            wb_rd_2,
  input  logic [XLEN-1:0]          wb_data_2,
  output logic                     wb_ready_2,
  input  logic                     stall,
  output logic [AW-1:0]            rd_1,
  output logic [XLEN-1:0]          writedata_1,
  output logic                     reg_write_1,
  output logic [AW-1:0]            rd_2,
  output logic [XLEN-1:0]          writedata_2,
  output logic                     reg_write_2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head, tail;
  logic [CW-1:0] count_q, free;
  logic [CW-1:0] n_push, n_pop;
  logic          push_1, push_2, waw;
  wb_entry_t     entry_0, entry_1, new_1, new_2;

  assign count = count_q;

  // Readiness depends only on registered occupancy, never on valid, so
  // lane 2 can only be accepted when lane 1 is as well.
  assign free       = CW'(DEPTH) - count_q;
  assign wb_ready_1 = (free >= CW'(1));
  assign wb_ready_2 = (free >= CW'(2));

  // A handshake to x0 completes but is dropped here.
  assign push_1 = wb_valid_1 & wb_ready_1 & (wb_rd_1 != REG_ZERO);
  assign push_2 = wb_valid_2 & wb_ready_2 & (wb_rd_2 != REG_ZERO);

  assign new_1 = '{rd: wb_rd_1, data: wb_data_1};
  assign new_2 = '{rd: wb_rd_2, data: wb_data_2};

  // Push/pop amounts for this edge; pops use the pre-edge occupancy.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    n_push = '0;
    n_pop  = '0;
    n_push = CW'(push_1) + CW'(push_2);
    if (!stall) n_pop = (count_q >= CW'(2)) ? CW'(2) : count_q;
  end

  wb_entry_store #(.DEPTH(DEPTH)) u_store (
    .clk     (clk),
    .we_a    (push_1),
    .waddr_a (tail),
    .wdata_a (new_1),
    .we_b    (push_2),
    .waddr_b (push_1 ? tail + PW'(1) : tail),
    .wdata_b (new_2),
    .raddr_0 (head),
    .rdata_0 (entry_0),
    .raddr_1 (head + PW'(1)),
    .rdata_1 (entry_1)
  );

  // Two entries to the same register in one drain: only the younger matters.
  assign waw = (n_pop == CW'(2)) && (entry_0.rd == entry_1.rd);

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      head    <= head + PW'(n_pop);
      tail    <= tail + PW'(n_push);
      count_q <= count_q + n_push - n_pop;
    end
  end

  // Register-file write port registers; address/data hold when nothing pops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_1        <= '0;
      writedata_1 <= '0;
      reg_write_1 <= 1'b0;
      rd_2        <= '0;
      writedata_2 <= '0;
      reg_write_2 <= 1'b0;
    end else begin
      reg_write_1 <= 1'b0;
      reg_write_2 <= 1'b0;
      if (n_pop >= CW'(1)) begin
        rd_1        <= entry_0.rd;
        writedata_1 <= entry_0.data;
        reg_write_1 <= ~waw;
      end
      if (n_pop == CW'(2)) begin
        rd_2        <= entry_1.rd;
        writedata_2 <= entry_1.data;
        reg_write_2 <= 1'b1;
      end
    end
  end

`ifdef WB_TRACE_EN
  localparam bit TRACE_EN = 1'b1;
  longint trace_cycle;

  initial begin
    trace_cycle = 0;
  end

  // Log each write as it is loaded into the port registers.
  always @(posedge clk) begin
    trace_cycle <= trace_cycle + 1;
    if (reset && n_pop >= CW'(1)) begin
      if (waw)
        $display("%0d 1 %0d %h %0d DROP", trace_cycle, entry_0.rd,
                 entry_0.data, $signed(entry_0.data));
      else
        $display("%0d 1 %0d %h %0d", trace_cycle, entry_0.rd,
                 entry_0.data, $signed(entry_0.data));
    end
    if (reset && n_pop == CW'(2))
      $display("%0d 2 %0d %h %0d", trace_cycle, entry_1.rd,
               entry_1.data, $signed(entry_1.data));
  end
`else
  localparam bit TRACE_EN = 1'b0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: directed scenarios followed by
// randomized traffic, checked against a FIFO-of-entries reference model
// with a scoreboard of expected register-file writes.
module tb_writeback_queue;
  import wb_defs::*;

  localparam int DEPTH = DEFAULT_WB_DEPTH;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            wb_valid_1 = 1'b0, wb_valid_2 = 1'b0, stall = 1'b0;
  logic [AW-1:0]   wb_rd_1 = '0, wb_rd_2 = '0;
  logic [XLEN-1:0] wb_data_1 = '0, wb_data_2 = '0;
  logic            wb_ready_1, wb_ready_2;
  logic [AW-1:0]   rd_1, rd_2;
  logic [XLEN-1:0] writedata_1, writedata_2;
  logic            reg_write_1, reg_write_2;
  logic [CW-1:0]   count;

  writeback_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .wb_valid_1(wb_valid_1), .wb_rd_1(wb_rd_1), .wb_data_1(wb_data_1), .wb_ready_1(wb_ready_1),
    .wb_valid_2(wb_valid_2), .wb_rd_2(wb_rd_2), .wb_data_2(wb_data_2), .wb_ready_2(wb_ready_2),
    .stall(stall),
    .rd_1(rd_1), .writedata_1(writedata_1), .reg_write_1(reg_write_1),
    .rd_2(rd_2), .writedata_2(writedata_2), .reg_write_2(reg_write_2),
    .count(count)
  );

  typedef struct {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } ent_t;

  typedef struct {
    int              cyc;
    int              port;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } exp_t;

  ent_t model[$];   // pending entries, oldest first
  exp_t sb[$];      // expected register-file writes, in issue order
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   done   = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon_write(input int port, input logic [AW-1:0] rd, input logic [XLEN-1:0] data);
    exp_t e;
    if (sb.size() == 0) begin
      check("unexpected_write", 64'(port), 64'(0));
    end else begin
      e = sb.pop_front();
      check("write_cycle", 64'(cyc), 64'(e.cyc));
      check("write_port", 64'(port), 64'(e.port));
      check("write_rd", 64'(rd), 64'(e.rd));
      check("write_data", 64'(data), 64'(e.data));
    end
  endtask

  // Monitor: consume expected writes whenever the DUT issues one, and flag
  // any expected write whose cycle has passed without being seen.
  always @(negedge clk) begin
    int overdue;
    if (reset && !done) begin
      if (reg_write_1) mon_write(1, rd_1, writedata_1);
      if (reg_write_2) mon_write(2, rd_2, writedata_2);
      overdue = 0;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        overdue++;
        void'(sb.pop_front());
      end
      check("missed_write", 64'(overdue), 64'(0));
    end
  end

  // One cycle of stimulus, called just after a falling edge. Checks the
  // occupancy/readiness the model predicts, drives inputs, then advances
  // the model by what the coming rising edge should do.
  task automatic step(input bit v1, input int r1, input logic [XLEN-1:0] d1,
                      input bit v2, input int r2, input logic [XLEN-1:0] d2,
                      input bit st);
    int   free, n;
    ent_t e0, e1;
    free = DEPTH - model.size();
    check("count", 64'(count), 64'(model.size()));
    check("ready_1", 64'(wb_ready_1), 64'(free >= 1));
    check("ready_2", 64'(wb_ready_2), 64'(free >= 2));
    wb_valid_1 = v1; wb_rd_1 = AW'(r1); wb_data_1 = d1;
    wb_valid_2 = v2; wb_rd_2 = AW'(r2); wb_data_2 = d2;
    stall      = st;
    if (!st) begin
      n = (model.size() < 2) ? model.size() : 2;
      if (n == 1) begin
        e0 = model.pop_front();
        sb.push_back('{cyc + 1, 1, e0.rd, e0.data});
      end else if (n == 2) begin
        e0 = model.pop_front();
        e1 = model.pop_front();
        if (e0.rd != e1.rd) sb.push_back('{cyc + 1, 1, e0.rd, e0.data});
        sb.push_back('{cyc + 1, 2, e1.rd, e1.data});
      end
    end
    if (v1 && free >= 1 && r1 != 0) model.push_back('{AW'(r1), d1});
    if (v2 && free >= 2 && r2 != 0) model.push_back('{AW'(r2), d2});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, '0, 0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_count", 64'(count), 64'(0));
    check("rst_reg_write_1", 64'(reg_write_1), 64'(0));
    check("rst_reg_write_2", 64'(reg_write_2), 64'(0));
    check("rst_rd_1", 64'(rd_1), 64'(0));
    check("rst_writedata_2", 64'(writedata_2), 64'(0));
    reset = 1'b1;
    @(negedge clk);

    // Single lane-1 write, one-cycle latency
    step(1, 3, 32'h11, 0, 0, '0, 0);
    idle(2);

    // Same-cycle WAW collapse
    step(1, 5, 32'hA, 1, 5, 32'hB, 0);
    idle(2);

    // Fill under stall, then drain in order
    step(1, 1, 32'h101, 1, 2, 32'h102, 1);
    step(1, 3, 32'h103, 1, 4, 32'h104, 1);
    step(1, 7, 32'h777, 1, 8, 32'h888, 1);   // full: both refused
    idle(3);

    // Move head/tail to 0, then reach count=3 and wrap the tail
    step(1, 12, 32'hC0, 0, 0, '0, 0);
    idle(2);
    step(1, 6, 32'h66, 1, 7, 32'h77, 1);
    step(1, 8, 32'h88, 0, 0, '0, 1);
    step(1, 9, 32'h99, 1, 10, 32'hAA, 1);    // only lane 1 fits, slot 3
    step(0, 0, '0, 0, 0, '0, 1);
    idle(3);

    // Write to x0: accepted but not queued
    step(1, 0, 32'hFF, 0, 0, '0, 0);
    idle(2);

    // Asynchronous reset with entries pending
    step(1, 13, 32'hD, 1, 14, 32'hE, 1);
    wb_valid_1 = 1'b0; wb_valid_2 = 1'b0; stall = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("midrst_count", 64'(count), 64'(0));
    check("midrst_reg_write_1", 64'(reg_write_1), 64'(0));
    check("midrst_reg_write_2", 64'(reg_write_2), 64'(0));
    check("midrst_writedata_1", 64'(writedata_1), 64'(0));
    model.delete();
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, int'($urandom_range(0, 7)), $urandom(),
           $urandom_range(0, 9) < 6, int'($urandom_range(0, 7)), $urandom(),
           $urandom_range(0, 3) == 0);
    end

    idle(4);
    check("scoreboard_empty", 64'(sb.size()), 64'(0));
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
